adler32_checker: RTL
====================

# adler32_checker

Streaming Adler-32 verifier: the receive-side counterpart of the Adler-32 checksum generator datapath. It accepts a byte stream of known length followed by a 4-byte big-endian Adler-32 trailer, recomputes the checksum on the fly and reports pass/fail. It sits behind the byte-stream receive interface, ahead of any consumer that needs integrity confirmation.

## Interface
- No parameters; modulus and initial values are fixed constants in the package.
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  begin a frame; sampled only in IDLE
- size  input  32  payload byte count, latched with start (0 legal)
- in_valid  input  1  in_data valid this cycle
- in_data  input  8  payload byte, then trailer bytes
- in_ready  output  1  checker can accept a byte this cycle
- busy  output  1  frame in progress (any state except IDLE)
- done  output  1  one-cycle pulse: verdict available
- match  output  1  computed == received; valid from done, held until next accepted start
- computed  output  32  {B, A} recomputed checksum; held with match
- received  output  32  trailer as received; held with match

## Operation
- States: IDLE, DATA, TRAILER, DONE.
- IDLE: in_ready=0. start=1 latches size into the byte counter, sets A=1, B=0, trailer counter=0, clears match. Goes to DATA if size!=0, else TRAILER.
- DATA: in_ready=1. Each accepted byte (in_valid&&in_ready) updates A'=(A+byte) mod 65521, then B'=(B+A') mod 65521, and decrements the byte counter. The accept that takes the counter from 1 to 0 moves to TRAILER.
- TRAILER: in_ready=1. Accepted bytes shift into received MSB-first: B[15:8], B[7:0], A[15:8], A[7:0]. The 4th accept moves to DONE.
- DONE: single cycle. done=1, match=(received=={B,A}), computed/received registered. Then IDLE.
- Modular add: 17-bit sum of two 16-bit operands; if sum>=65521, subtract 65521. Operands are always <65521, so one subtraction suffices. The byte operand is zero-extended.
- start outside IDLE is ignored and does not affect the current frame.
- in_data is ignored when in_valid=0 or in_ready=0.

## Timing
- Reset values: state=IDLE, A=1, B=0, byte counter=0, trailer counter=0, received=0, computed=0x00000001, in_ready=0, busy=0, done=0, match=0.
- Reset mid-frame: abandons the frame immediately. No done pulse is produced. All reset values apply on the next cycle.
- One byte per cycle maximum. No combinational path from in_valid to in_ready; in_ready is decoded from state only.
- start accepted at edge N: busy=1 and in_ready=1 from cycle N+1.
- Last trailer byte accepted at edge M: done=1 during cycle M+1, busy=0 and in_ready=0 from cycle M+2.
- Frame latency with continuous in_valid: size+4 accept cycles, +1 DONE cycle.
- A back-to-back start is accepted on the first IDLE cycle after DONE.
- Gaps in in_valid stall the state without changing A, B, or the counters.

## Structure
- Package adler32_pkg: ADLER_MOD=16'd65521, ADLER_A_INIT=16'd1, ADLER_B_INIT=16'd0, and the state enum (IDLE, DATA, TRAILER, DONE).
- Sub-module adler32_mod_add: combinational 16+16 → 16 modular adder, instantiated twice and chained (A then B).
- The top level holds the FSM, the 32-bit byte counter, the 2-bit trailer counter, and the 32-bit received shift register.

## Test plan
- Nominal: start with size=9, send "Wikipedia", then trailer 11 E6 03 98 → done=1, match=1, computed=0x11E60398.
- Corrupt trailer: same payload, trailer 11 E6 03 99 → match=0, computed=0x11E60398, received=0x11E60399.
- Empty frame and wrap: size=0 with trailer 00 00 00 01 → match=1 after 4 accepts. Separately, size=1024 of 0xFF with trailer 79 A6 FC 2E → match=1, exercising mod-65521 wrap on both A and B.
- Backpressure and start abuse: nominal frame with in_valid toggling 1-0-0-1 → same result as unstalled. A start pulse mid-DATA is ignored and frame results are unchanged.
- Reset mid-frame: rst_n=0 for 1 cycle after 5 payload bytes → no done; busy=0, in_ready=0, computed=0x00000001. A following full nominal frame passes.
- Back-to-back: start asserted in the cycle right after done → second frame accepted with no idle gap beyond IDLE, and both verdicts are correct.

Source files
------------

// File: rtl/adler32_pkg.sv
// Shared constants and state encoding for the Adler-32 receive-side checker.
package adler32_pkg;

   localparam logic [15:0] ADLER_MOD    = 16'd65521;
   localparam logic [15:0] ADLER_A_INIT = 16'd1;
   localparam logic [15:0] ADLER_B_INIT = 16'd0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DATA    = 2'd1,
      TRAILER = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/adler32_checker_if.sv
// Byte-stream receive interface feeding the Adler-32 checker.
// Handshake: a byte transfers on a rising clk edge where in_valid and in_ready
// are both 1; in_data is a don't-care otherwise. in_ready never depends on
// in_valid, and the source may raise or drop in_valid in any cycle.
interface adler32_checker_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/adler32_mod_add.sv
// Combinational 16+16 -> 16 adder modulo 65521; operands are always < 65521,
// so a single conditional subtraction brings the result back in range.
module adler32_mod_add
   import adler32_pkg::*;
(
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic [15:0] sum
);

   logic [16:0] raw;

   // Wide sum, then fold once if it reached the modulus.
   always_comb begin
      raw = {1'b0, op_a} + {1'b0, op_b};
      if (raw >= {1'b0, ADLER_MOD}) begin
         sum = raw[15:0] - ADLER_MOD;
      end else begin
         sum = raw[15:0];
      end
   end

endmodule

// File: rtl/adler32_checker.sv
// Streaming Adler-32 verifier: recomputes the checksum over a sized payload,
// collects the 4-byte big-endian trailer and reports whether they agree.
module adler32_checker
   import adler32_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [31:0]         size,
   adler32_checker_if.slave    bus,
   output logic                busy,
   output logic                done,
   output logic                match,
   output logic [31:0]         computed,
   output logic [31:0]         received,
   output state_t              dbg_state
);

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  tcnt_q, tcnt_d;
   logic [31:0] recv_q, recv_d;
   logic [31:0] comp_q, comp_d;
   logic        match_q, match_d;
   logic        in_ready_s;
   logic        accept;
   logic [15:0] a_sum, b_sum;
   logic [31:0] recv_shift;

   assign accept     = bus.in_valid && in_ready_s;
   assign recv_shift = {recv_q[23:0], bus.in_data};

   // A is updated first; the new A feeds the B update in the same cycle.
   adler32_mod_add u_add_a (.op_a(a_q), .op_b({8'd0, bus.in_data}), .sum(a_sum));
   adler32_mod_add u_add_b (.op_a(b_q), .op_b(a_sum),               .sum(b_sum));

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= ADLER_A_INIT;
         b_q     <= ADLER_B_INIT;
         cnt_q   <= 32'd0;
         tcnt_q  <= 2'd0;
         recv_q  <= 32'd0;
         comp_q  <= {ADLER_B_INIT, ADLER_A_INIT};
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         recv_q  <= recv_d;
         comp_q  <= comp_d;
         match_q <= match_d;
      end
   end

   // Next-state logic: start only matters in IDLE, stalls hold the state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (size == 32'd0) ? TRAILER : DATA;
         DATA:    if (accept && (cnt_q == 32'd1)) state_d = TRAILER;
         TRAILER: if (accept && (tcnt_q == 2'd3)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates; verdict is captured on the last trailer accept so it is
   // already visible while done is high.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      recv_d  = recv_q;
      comp_d  = comp_q;
      match_d = match_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = size;
               a_d     = ADLER_A_INIT;
               b_d     = ADLER_B_INIT;
               tcnt_d  = 2'd0;
               match_d = 1'b0;
            end
         end
         DATA: begin
            if (accept) begin
               a_d   = a_sum;
               b_d   = b_sum;
               cnt_d = cnt_q - 32'd1;
            end
         end
         TRAILER: begin
            if (accept) begin
               recv_d = recv_shift;
               tcnt_d = tcnt_q + 2'd1;
               if (tcnt_q == 2'd3) begin
                  comp_d  = {b_q, a_q};
                  match_d = (recv_shift == {b_q, a_q});
               end
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from state only.
   always_comb begin
      in_ready_s = (state_q == DATA) || (state_q == TRAILER);
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
   end

   assign bus.in_ready = in_ready_s;
   assign match        = match_q;
   assign computed     = comp_q;
   assign received     = recv_q;
   assign dbg_state    = state_q;

endmodule
